fm_seq_ddr_wr: RTL and testbench

FM_SEQ_DDR_WR -- requirements
Module: fm_seq_ddr_wr

---
 rtl/fm_seq_ddr_wr.sv | 139 +++++++++++++
 tb/tb_fm_seq_ddr_wr.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_seq_ddr_wr.sv
// fm_seq_ddr_wr: buffers an upstream word stream in a small FIFO and issues
// each word to a DDR application port as one write command plus one write
// data beat, with independent command/data handshakes and an auto-advancing
// address counter.
module fm_seq_ddr_wr #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int FIFO_DEPTH     = 16,
  parameter int ADDR_STRIDE    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [APP_DATA_WIDTH-1:0]   seq,
  input  logic                        seq_valid,
  input  logic                        seq_last,
  input  logic [APP_ADDR_WIDTH-1:0]   addr_base,
  input  logic                        addr_load,
  output logic [APP_ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  input  logic                        app_rdy,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                        app_wdf_rdy,
  output logic                        busy,
  output logic                        burst_done,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  // Each entry carries the last-of-burst tag above the data word.
  logic [APP_DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PW:0]               cnt_q, cnt_d;
  state_t                    state_q, state_d;
  logic                      cmd_done_q, cmd_done_d;
  logic                      dat_done_q, dat_done_d;
  logic                      app_en_q, app_en_d;
  logic                      wren_q, wren_d;
  logic                      burst_done_q, burst_done_d;
  logic                      overflow_q, overflow_d;
  logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      cmd_acc;
  logic                      dat_acc;
  logic [APP_DATA_WIDTH:0]   head;

  assign head    = mem_q[rd_ptr_q];
  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign cmd_acc = app_en_q & app_rdy;
  assign dat_acc = wren_q & app_wdf_rdy;
  // A word retires once both sides have been accepted, now or earlier.
  assign pop     = (state_q == ISSUE) & (cmd_done_q | cmd_acc) & (dat_done_q | dat_acc);
  // Full FIFO still accepts when the head leaves in the same cycle.
  assign push    = seq_valid & (~full | pop);

  assign busy         = (cnt_q != '0) | (state_q != IDLE);
  assign app_addr     = addr_q;
  assign app_cmd      = 3'b000;
  assign app_en       = app_en_q;
  assign app_wdf_data = head[APP_DATA_WIDTH-1:0];
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign app_wdf_mask = '0;
  assign burst_done   = burst_done_q;
  assign overflow     = overflow_q;

  // Next-state logic for FIFO pointers, handshake tracking, address and FSM.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    state_d      = state_q;
    addr_d       = addr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d        = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    overflow_d   = overflow_q | (seq_valid & ~push);
    burst_done_d = pop & head[APP_DATA_WIDTH];
    cmd_done_d   = pop ? 1'b0 : (cmd_done_q | cmd_acc);
    dat_done_d   = pop ? 1'b0 : (dat_done_q | dat_acc);
    if (pop) begin
      addr_d = addr_q + APP_ADDR_WIDTH'(ADDR_STRIDE);
    end else if (addr_load && !busy) begin
      addr_d = addr_base;
    end
    case (state_q)
      IDLE:    if (cnt_q != '0) state_d = ISSUE;
      ISSUE:   if (pop && cnt_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Valids are registered; each drops once its side has been accepted.
    app_en_d = (state_d == ISSUE) & ~cmd_done_d;
    wren_d   = (state_d == ISSUE) & ~dat_done_d;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      cmd_done_q   <= 1'b0;
      dat_done_q   <= 1'b0;
      app_en_q     <= 1'b0;
      wren_q       <= 1'b0;
      burst_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      addr_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      cmd_done_q   <= cmd_done_d;
      dat_done_q   <= dat_done_d;
      app_en_q     <= app_en_d;
      wren_q       <= wren_d;
      burst_done_q <= burst_done_d;
      overflow_q   <= overflow_d;
      addr_q       <= addr_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {seq_last, seq};
  end

endmodule

// File: tb/tb_fm_seq_ddr_wr.sv
// Testbench for fm_seq_ddr_wr: directed scenarios plus randomized bursts,
// checked against a queue-based model of the expected DDR write stream.
module tb_fm_seq_ddr_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] seq = '0;
  logic        seq_valid = 1'b0;
  logic        seq_last = 1'b0;
  logic [27:0] addr_base = '0;
  logic        addr_load = 1'b0;
  logic [27:0] app_addr;
  logic [2:0]  app_cmd;
  logic        app_en;
  logic        app_rdy = 1'b0;
  logic [63:0] app_wdf_data;
  logic        app_wdf_wren;
  logic        app_wdf_end;
  logic [7:0]  app_wdf_mask;
  logic        app_wdf_rdy = 1'b0;
  logic        busy;
  logic        burst_done;
  logic        overflow;

  fm_seq_ddr_wr dut (
    .clk(clk), .rst(rst), .seq(seq), .seq_valid(seq_valid), .seq_last(seq_last),
    .addr_base(addr_base), .addr_load(addr_load), .app_addr(app_addr),
    .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_wdf_rdy(app_wdf_rdy), .busy(busy), .burst_done(burst_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: expected writes in order, plus expected burst count.
  logic [27:0] exp_a[$];
  logic [63:0] exp_d[$];
  logic [27:0] m_addr = '0;
  int          exp_bd = 0;

  // Observed DUT activity.
  logic [27:0] obs_a[$];
  logic [63:0] obs_d[$];
  int          bd_cnt = 0;
  int          inv_bad = 0;
  int          stab_bad = 0;
  bit          rand_rdy = 1'b0;

  logic        pend_c = 1'b0, pend_d = 1'b0;
  logic [27:0] p_addr = '0;
  logic [63:0] p_data = '0;

  // Monitor, sampled on the falling edge: accepted handshakes, constant
  // outputs and stability of pending requests.
  always @(negedge clk) begin
    if (app_cmd !== 3'b000 || app_wdf_mask !== 8'h00 || app_wdf_end !== app_wdf_wren) inv_bad++;
    if (!rst && pend_c && !(app_en === 1'b1 && app_addr === p_addr)) stab_bad++;
    if (!rst && pend_d && !(app_wdf_wren === 1'b1 && app_wdf_data === p_data)) stab_bad++;
    pend_c = !rst && app_en && !app_rdy;
    pend_d = !rst && app_wdf_wren && !app_wdf_rdy;
    p_addr = app_addr;
    p_data = app_wdf_data;
    if (!rst && app_en && app_rdy) obs_a.push_back(app_addr);
    if (!rst && app_wdf_wren && app_wdf_rdy) obs_d.push_back(app_wdf_data);
    if (!rst && burst_done) bd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      app_rdy     = 1'($urandom_range(0, 1));
      app_wdf_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_clear();
    exp_a.delete(); exp_d.delete(); obs_a.delete(); obs_d.delete();
    exp_bd = 0; bd_cnt = 0;
  endtask

  task automatic model_push(input logic [63:0] d, input bit last);
    exp_a.push_back(m_addr);
    exp_d.push_back(d);
    m_addr = m_addr + 28'd8;
    if (last) exp_bd++;
  endtask

  task automatic push_word(input logic [63:0] d, input bit last);
    seq = d; seq_valid = 1'b1; seq_last = last;
    tick();
    seq_valid = 1'b0; seq_last = 1'b0;
  endtask

  task automatic do_load(input logic [27:0] base);
    addr_base = base; addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
    m_addr = base;
  endtask

  task automatic do_reset();
    rst = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    m_addr = '0;
    model_clear();
  endtask

  task automatic drain_and_compare(input string tag);
    int n = 0;
    int na, nd;
    if (!rand_rdy) begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
    while (busy && n < 500) begin tick(); n++; end
    chk({tag, "_idle"}, 64'(busy), 64'(0));
    tick(); tick();
    chk({tag, "_ncmd"}, 64'(obs_a.size()), 64'(exp_a.size()));
    chk({tag, "_ndat"}, 64'(obs_d.size()), 64'(exp_d.size()));
    chk({tag, "_bursts"}, 64'(bd_cnt), 64'(exp_bd));
    na = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    nd = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
    for (int i = 0; i < na; i++) chk($sformatf("%s_addr%0d", tag, i), 64'(obs_a[i]), 64'(exp_a[i]));
    for (int i = 0; i < nd; i++) chk($sformatf("%s_data%0d", tag, i), obs_d[i], exp_d[i]);
    model_clear();
  endtask

  initial begin
    int n;
    logic [63:0] w;

    // Reset state, observed while rst is held.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_app_en", 64'(app_en), 64'(0));
    chk("rst_wren", 64'(app_wdf_wren), 64'(0));
    chk("rst_addr", 64'(app_addr), 64'(0));
    chk("rst_burst_done", 64'(burst_done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    model_clear();

    // Five-word burst with both sides always ready.
    do_load(28'h100);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = 64'hD0D0_0000_0000_0000 + 64'(i);
      model_push(w, i == 4);
      push_word(w, i == 4);
    end
    drain_and_compare("burst5");

    // Data side stalled while command side is ready.
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    w = 64'hCAFE_F00D_1234_5678;
    model_push(w, 1'b1);
    push_word(w, 1'b1);
    repeat (4) tick();
    chk("stall_ncmd", 64'(obs_a.size()), 64'(1));
    chk("stall_app_en", 64'(app_en), 64'(0));
    chk("stall_wren", 64'(app_wdf_wren), 64'(1));
    chk("stall_data", app_wdf_data, w);
    chk("stall_ndat", 64'(obs_d.size()), 64'(0));
    chk("stall_busy", 64'(busy), 64'(1));
    drain_and_compare("stall");

    // Overflow: 17 words into a 16-deep FIFO with nothing draining.
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      w = {32'hABCD_0000, 32'(i)};
      if (i < 16) model_push(w, i == 16);
      push_word(w, i == 16);
    end
    tick();
    chk("ovf_flag", 64'(overflow), 64'(1));
    drain_and_compare("ovf");
    chk("ovf_sticky", 64'(overflow), 64'(1));
    do_reset();
    chk("ovf_cleared", 64'(overflow), 64'(0));

    // addr_load ignored while busy, honoured when idle.
    do_load(28'h300);
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = 64'h3000 + 64'(i);
      model_push(w, i == 2);
      push_word(w, i == 2);
    end
    chk("load_busy_pre", 64'(busy), 64'(1));
    addr_base = 28'h5000; addr_load = 1'b1;
    tick();
    addr_load = 1'b0;
    drain_and_compare("load_ignored");
    do_load(28'h400);
    model_push(64'h4444, 1'b1);
    push_word(64'h4444, 1'b1);
    drain_and_compare("load_idle");

    // Address wrap at the top of the 28-bit space.
    do_load(28'hFFFFFF8);
    model_push(64'h1111, 1'b0);
    push_word(64'h1111, 1'b0);
    model_push(64'h2222, 1'b1);
    push_word(64'h2222, 1'b1);
    drain_and_compare("wrap");

    // Reset in the middle of a burst after two words are written.
    do_load(28'h200);
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = 64'h2000 + 64'(i);
      model_push(w, i == 4);
      push_word(w, i == 4);
    end
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    n = 0;
    while (obs_d.size() < 2 && n < 100) begin tick(); n++; end
    rst = 1'b1; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    tick();
    rst = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    chk("mid_rst_no_issue", 64'(app_en | app_wdf_wren), 64'(0));
    repeat (5) tick();
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_app_en", 64'(app_en), 64'(0));
    chk("mid_rst_addr", 64'(app_addr), 64'(0));
    chk("mid_rst_ndat", 64'(obs_d.size()), 64'(2));
    chk("mid_rst_ncmd", 64'(obs_a.size()), 64'(2));
    if (obs_d.size() >= 2) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mid_rst_addr%0d", i), 64'(obs_a[i]), 64'(exp_a[i]));
        chk($sformatf("mid_rst_data%0d", i), obs_d[i], exp_d[i]);
      end
    end
    m_addr = '0;
    model_clear();

    // Randomized bursts with random ready behaviour on both sides.
    rand_rdy = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int len;
      if ($urandom_range(0, 2) == 0) do_load(28'($urandom));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        w = {$urandom, $urandom};
        model_push(w, j == len - 1);
        push_word(w, j == len - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain_and_compare($sformatf("rand%0d", it));
    end
    rand_rdy = 1'b0;

    chk("const_outputs", 64'(inv_bad), 64'(0));
    chk("pending_stable", 64'(stab_bad), 64'(0));
    chk("rand_no_overflow", 64'(overflow), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
